// File: rtl/gctr_block_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gctr_block_pkg
//  Purpose  : Shared definitions for the GCTR block and its AES engine:
//             FSM state encoding, operation-type encoding, counter
//             constants, key-length encodings and the AES S-box.
//  Ports    : (package - no ports)
//  Revision : 1.0 - initial release
// ============================================================================
package gctr_block_pkg;

  // Wrapper FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Operation captured at start
  typedef enum logic [1:0] {
    OP_HASHKEY = 2'd0,
    OP_Y0      = 2'd1,
    OP_BLOCK   = 2'd2
  } op_e;

  // Counter value after reset (J0 uses 1, first data block uses 2)
  localparam logic [31:0] CTR_INIT = 32'h0000_0002;
  // Counter field of the pre-counter block J0
  localparam logic [31:0] J0_CTR   = 32'h0000_0001;

  // Key-length encodings
  localparam logic KEYLEN_128 = 1'b0;
  localparam logic KEYLEN_256 = 1'b1;

  // Number of AES rounds per key length
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_256 = 4'd14;

  // AES S-box, entry 0 in the most significant byte
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[2047 - 8 * int'(x) -: 8];
  endfunction

endpackage : gctr_block_pkg
`default_nettype wire

// File: rtl/gctr_block_aes_core.sv
`default_nettype none
// ============================================================================
//  Module   : aes_core
//  Purpose  : Encrypt-only iterative AES-128/AES-256 engine, one round per
//             clock, with on-the-fly key expansion.
//  Ports    : clk    - clock, rising edge
//             rst_n  - asynchronous active-low reset
//             start  - one-cycle pulse; samples key, keylen and block
//             key    - 256-bit key; AES-128 uses key[255:128]
//             keylen - 0 = AES-128, 1 = AES-256
//             block  - 128-bit plaintext block
//             result - ciphertext, held until the next completion
//             ready  - one-cycle pulse when result has just been updated
//  Revision : 1.0 - initial release
// ============================================================================
module aes_core
  import gctr_block_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] key,
  input  logic         keylen,
  input  logic [127:0] block,
  output logic [127:0] result,
  output logic         ready
);

  // Bytes are column-major: byte n = row (n%4) of column (n/4), byte 0 at MSB.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = sbox(s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Next 4 schedule words: 'far' is the round key Nk words back, 'last' the
  // most recent word. rot selects RotWord+Rcon (vs SubWord-only for AES-256).
  function automatic logic [127:0] next_rk(input logic [127:0] far,
                                           input logic [31:0]  last,
                                           input logic         rot,
                                           input logic [7:0]   rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = rot ? (sub_word({last[23:0], last[31:24]}) ^ {rc, 24'h0}) : sub_word(last);
    w0 = far[127:96] ^ t;
    w1 = far[95:64]  ^ w0;
    w2 = far[63:32]  ^ w1;
    w3 = far[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  logic [127:0] st_q, st_d;
  // Key window: AES-128 keeps the previous round key in ka; AES-256 keeps
  // the two previous round keys (ka older, kb newer).
  logic [127:0] ka_q, ka_d;
  logic [127:0] kb_q, kb_d;
  logic [3:0]   round_q, round_d;
  logic         busy_q, busy_d;
  logic         len_q, len_d;
  logic [127:0] result_q, result_d;
  logic         ready_q, ready_d;

  logic [3:0]   last_round;
  logic [127:0] rk;
  logic [127:0] ss;
  logic [127:0] round_out;

  always_comb begin
    st_d       = st_q;
    ka_d       = ka_q;
    kb_d       = kb_q;
    round_d    = round_q;
    busy_d     = busy_q;
    len_d      = len_q;
    result_d   = result_q;
    ready_d    = 1'b0;

    last_round = (len_q == KEYLEN_256) ? NR_256 : NR_128;

    if (len_q == KEYLEN_128) begin
      rk = next_rk(ka_q, ka_q[31:0], 1'b1, rcon(round_q));
    end else if (round_q == 4'd1) begin
      rk = kb_q;                       // second half of the key is round key 1
    end else if (!round_q[0]) begin
      rk = next_rk(ka_q, kb_q[31:0], 1'b1, rcon({1'b0, round_q[3:1]}));
    end else begin
      rk = next_rk(ka_q, kb_q[31:0], 1'b0, 8'h00);
    end

    ss        = sub_shift(st_q);
    round_out = ((round_q == last_round) ? ss : mix_columns(ss)) ^ rk;

    if (start) begin
      st_d    = block ^ key[255:128];
      ka_d    = key[255:128];
      kb_d    = key[127:0];
      round_d = 4'd1;
      busy_d  = 1'b1;
      len_d   = keylen;
    end else if (busy_q) begin
      st_d = round_out;
      if (len_q == KEYLEN_128) begin
        ka_d = rk;
      end else if (round_q != 4'd1) begin
        ka_d = kb_q;
        kb_d = rk;
      end
      if (round_q == last_round) begin
        busy_d   = 1'b0;
        result_d = round_out;
        ready_d  = 1'b1;
      end else begin
        round_d = round_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= '0;
      ka_q     <= '0;
      kb_q     <= '0;
      round_q  <= '0;
      busy_q   <= 1'b0;
      len_q    <= KEYLEN_128;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      st_q     <= st_d;
      ka_q     <= ka_d;
      kb_q     <= kb_d;
      round_q  <= round_d;
      busy_q   <= busy_d;
      len_q    <= len_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result = result_q;
  assign ready  = ready_q;

endmodule : aes_core
`default_nettype wire

// File: rtl/gctr_block.sv
`default_nettype none
// ============================================================================
//  Module   : gctr_block
//  Purpose  : GCM counter-mode (GCTR) wrapper around an iterative AES core.
//             Produces the hash key H = E(K,0), the tag mask E(K,J0) and
//             counter-mode data blocks; encryption and decryption coincide.
//  Ports    : iClk          - clock, rising edge
//             iRstn         - asynchronous active-low reset
//             iInit         - request enable, sampled in IDLE only
//             iIV/_valid    - 96-bit IV, latched at start when valid
//             iKey/_valid   - 256-bit key, latched with iKeylen when valid
//             iKeylen       - 0 = AES-128 (iKey[0:127]), 1 = AES-256
//             iHashKey      - request H = E(K, 0^128)
//             iY0           - request E(K, IV || 0x00000001)
//             iBlock/_valid - data block for a counter-mode operation
//             oResult       - result, held until the next completion
//             oResult_valid - one-cycle pulse when oResult is updated
//  Revision : 1.0 - initial release
// ============================================================================
module gctr_block
  import gctr_block_pkg::*;
(
  input  logic         iClk,
  input  logic         iRstn,
  input  logic         iInit,
  input  logic [0:95]  iIV,
  input  logic         iIV_valid,
  input  logic [0:255] iKey,
  input  logic         iKey_valid,
  input  logic         iKeylen,
  input  logic         iHashKey,
  input  logic         iY0,
  input  logic [0:127] iBlock,
  input  logic         iBlock_valid,
  output logic [0:127] oResult,
  output logic         oResult_valid
);

  state_e       state_q, state_d;
  op_e          op_q, op_d;
  logic [255:0] key_q, key_d;
  logic         keylen_q, keylen_d;
  logic [95:0]  iv_q, iv_d;
  logic [31:0]  ctr_q, ctr_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] res_q, res_d;
  logic         res_valid_q, res_valid_d;

  logic         aes_start;
  logic [127:0] aes_block;
  logic [127:0] aes_result;
  logic         aes_ready;
  logic         req;

  // AES input is a pure function of latched state, stable through LOAD.
  always_comb begin
    case (op_q)
      OP_HASHKEY: aes_block = '0;
      OP_Y0:      aes_block = {iv_q, J0_CTR};
      default:    aes_block = {iv_q, ctr_q};
    endcase
  end

  assign aes_start = (state_q == ST_LOAD);
  assign req       = iInit && (iHashKey || iY0 || iBlock_valid);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    key_d       = key_q;
    keylen_d    = keylen_q;
    iv_d        = iv_q;
    ctr_d       = ctr_q;
    blk_d       = blk_q;
    res_d       = res_q;
    res_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_LOAD;
          if (iHashKey) begin
            op_d = OP_HASHKEY;
          end else if (iY0) begin
            op_d = OP_Y0;
          end else begin
            op_d = OP_BLOCK;
          end
          blk_d = iBlock;
          if (iKey_valid) begin
            key_d    = iKey;
            keylen_d = iKeylen;
          end
          if (iIV_valid) begin
            iv_d = iIV;
          end
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (aes_ready) begin
          state_d     = ST_DONE;
          res_valid_d = 1'b1;
          if (op_q == OP_BLOCK) begin
            res_d = blk_q ^ aes_result;
            // Only the low 32 bits count; natural wrap at 2^32.
            ctr_d = ctr_q + 32'd1;
          end else begin
            res_d = aes_result;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_HASHKEY;
      key_q       <= '0;
      keylen_q    <= KEYLEN_128;
      iv_q        <= '0;
      ctr_q       <= CTR_INIT;
      blk_q       <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      key_q       <= key_d;
      keylen_q    <= keylen_d;
      iv_q        <= iv_d;
      ctr_q       <= ctr_d;
      blk_q       <= blk_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
    end
  end

  aes_core u_aes_core (
    .clk    (iClk),
    .rst_n  (iRstn),
    .start  (aes_start),
    .key    (key_q),
    .keylen (keylen_q),
    .block  (aes_block),
    .result (aes_result),
    .ready  (aes_ready)
  );

  assign oResult       = res_q;
  assign oResult_valid = res_valid_q;

endmodule : gctr_block
`default_nettype wire

// File: tb/tb_gctr_block.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gctr_block
//  Purpose  : Self-checking bench for gctr_block using the IEEE 802.1AE
//             60-byte GCM-AES-128/256 vectors plus reset, priority,
//             input-isolation and back-to-back sequences.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_gctr_block;

  logic         iClk = 1'b0;
  logic         iRstn;
  logic         iInit;
  logic [0:95]  iIV;
  logic         iIV_valid;
  logic [0:255] iKey;
  logic         iKey_valid;
  logic         iKeylen;
  logic         iHashKey;
  logic         iY0;
  logic [0:127] iBlock;
  logic         iBlock_valid;
  logic [0:127] oResult;
  logic         oResult_valid;

  gctr_block dut (
    .iClk          (iClk),
    .iRstn         (iRstn),
    .iInit         (iInit),
    .iIV           (iIV),
    .iIV_valid     (iIV_valid),
    .iKey          (iKey),
    .iKey_valid    (iKey_valid),
    .iKeylen       (iKeylen),
    .iHashKey      (iHashKey),
    .iY0           (iY0),
    .iBlock        (iBlock),
    .iBlock_valid  (iBlock_valid),
    .oResult       (oResult),
    .oResult_valid (oResult_valid)
  );

  always #5 iClk = ~iClk;

  localparam logic [0:255] K256  = 256'hE3C08A8F06C6E3AD95A70557B23F75483CE33021A9C72B7025666204C69C0B72;
  localparam logic [0:255] K128  = {128'hAD7A2BD03EAC835A6F620FDCB506B345, 128'h0};
  localparam logic [0:255] KGARB = {8{32'hA5A5_5A5A}};
  localparam logic [0:95]  IV    = 96'h12153524C0895E81B2C28465;
  localparam logic [0:95]  IVGARB = 96'hDEADBEEF_0BADF00D_CAFEF00D;
  localparam logic [0:127] P1 = 128'h08000F101112131415161718191A1B1C;
  localparam logic [0:127] P2 = 128'h1D1E1F202122232425262728292A2B2C;
  localparam logic [0:127] P3 = 128'h2D2E2F303132333435363738393A0002;
  localparam logic [0:127] C1 = 128'hE2006EB42F5277022D9B19925BC419D7;
  localparam logic [0:127] C2 = 128'hA592666C925FE2EF718EB4E308EFEAA7;
  localparam logic [0:127] C3 = 128'hC5273B394118860A5BE2A97F56AB7836;
  localparam logic [0:127] H256 = 128'h286D73994EA0BA3CFD1F52BF06A8ACF2;
  localparam logic [0:127] Y0_256 = 128'h714D54FDCFCEE37D5729CDDAB383A016;
  localparam logic [0:127] H128 = 128'h73A23D80121DE2D5A850253FCF43120E;
  localparam logic [0:127] D1 = 128'h701AFA1CC039C0D765128A665DAB6924;
  localparam logic [0:127] D2 = 128'h3899BF7318CCDC81C9931DA17FBE8EDD;
  localparam logic [0:127] D3 = 128'h7D17CB8B4C26FC81E3284F2B7FBA713D;
  localparam logic [0:127] ZERO = 128'h0;

  typedef struct {
    bit           rst;
    bit           hk;
    bit           y0;
    bit           bv;
    bit           kv;
    bit           kl;
    bit           ivv;
    logic [0:127] blk;
    logic [0:127] exp;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  int n_checks = 0;
  int n_fail   = 0;
  int lat_ref [2];
  bit cur_kl = 1'b0;

  function automatic vec_t mk(bit rst, bit hk, bit y0, bit bv, bit kv, bit kl, bit ivv,
                              logic [0:127] blk, logic [0:127] exp);
    vec_t v;
    v.rst = rst; v.hk = hk; v.y0 = y0; v.bv = bv;
    v.kv = kv; v.kl = kl; v.ivv = ivv; v.blk = blk; v.exp = exp;
    return v;
  endfunction

  task automatic check128(input string name, input logic [0:127] got, input logic [0:127] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input bit ok, input int got, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge iClk);
    iRstn = 1'b0;
    iInit = 1'b0; iHashKey = 1'b0; iY0 = 1'b0; iBlock_valid = 1'b0;
    repeat (2) @(negedge iClk);
    check128("reset_result", oResult, ZERO);
    check_int("reset_valid", oResult_valid == 1'b0, int'(oResult_valid), 0);
    iRstn = 1'b1;
  endtask

  // Drive one request in the next cycle, scramble all inputs afterwards,
  // optionally re-assert requests while busy, then check the single result.
  task automatic run_op(input bit hk, input bit y0, input bit bv, input bit kv, input bit kl,
                        input bit ivv, input logic [0:127] blk, input logic [0:127] exp,
                        input string name, input bit disturb);
    bit seen;
    int lat;
    @(negedge iClk);
    iInit = 1'b1; iHashKey = hk; iY0 = y0; iBlock_valid = bv; iBlock = blk;
    iKey_valid = kv; iKey = kv ? (kl ? K256 : K128) : KGARB; iKeylen = kl;
    iIV_valid = ivv; iIV = ivv ? IV : IVGARB;
    if (kv) cur_kl = kl;
    @(posedge iClk);
    #1;
    iInit = 1'b0; iHashKey = 1'b0; iY0 = 1'b0; iBlock_valid = 1'b0;
    iBlock = {$urandom, $urandom, $urandom, $urandom};
    iKey = KGARB ^ {8{$urandom}};
    iIV = IVGARB ^ {$urandom, $urandom, $urandom};
    iKey_valid = 1'b1; iIV_valid = 1'b1; iKeylen = ~cur_kl;
    seen = 1'b0;
    lat = 0;
    for (int c = 1; c <= 25 && !seen; c++) begin
      @(negedge iClk);
      if (disturb && c == 4) begin
        iInit = 1'b1; iHashKey = 1'b1; iY0 = 1'b1; iBlock_valid = 1'b1;
      end
      if (disturb && c == 8) begin
        iInit = 1'b0; iHashKey = 1'b0; iY0 = 1'b0; iBlock_valid = 1'b0;
      end
      if (oResult_valid) begin
        seen = 1'b1;
        lat = c;
      end
    end
    if (!seen) begin
      check_int({name, "_timeout"}, 1'b0, 25, 20);
    end else begin
      check128(name, oResult, exp);
      check_int({name, "_latency_max"}, lat <= 20, lat, 20);
      if (lat_ref[cur_kl] == 0) begin
        lat_ref[cur_kl] = lat;
      end else begin
        check_int({name, "_latency_const"}, lat == lat_ref[cur_kl], lat, lat_ref[cur_kl]);
      end
      @(posedge iClk);
      #1;
      check_int({name, "_pulse_width"}, oResult_valid == 1'b0, int'(oResult_valid), 0);
    end
  endtask

  // No valid pulse and a held result for n cycles.
  task automatic watch_quiet(input string name, input int n, input logic [0:127] hold);
    bit ok;
    ok = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(negedge iClk);
      if (oResult_valid || oResult !== hold) ok = 1'b0;
    end
    check_int(name, ok, int'(ok), 1);
  endtask

  initial begin
    vecs[0]  = mk(1, 1, 0, 0, 1, 1, 1, ZERO, H256);
    vecs[1]  = mk(0, 0, 0, 1, 0, 1, 0, P1,   C1);
    vecs[2]  = mk(0, 0, 0, 1, 0, 1, 0, P2,   C2);
    vecs[3]  = mk(0, 0, 0, 1, 0, 1, 0, P3,   C3);
    vecs[4]  = mk(0, 0, 1, 0, 0, 1, 0, P1,   Y0_256);
    vecs[5]  = mk(1, 1, 0, 0, 1, 1, 1, ZERO, H256);
    vecs[6]  = mk(0, 0, 0, 1, 0, 1, 0, C1,   P1);
    vecs[7]  = mk(0, 0, 0, 1, 0, 1, 0, C2,   P2);
    vecs[8]  = mk(0, 0, 0, 1, 0, 1, 0, C3,   P3);
    vecs[9]  = mk(1, 1, 0, 0, 1, 0, 1, ZERO, H128);
    vecs[10] = mk(0, 0, 0, 1, 0, 0, 0, P1,   D1);
    vecs[11] = mk(0, 0, 0, 1, 0, 0, 0, P2,   D2);
    vecs[12] = mk(0, 0, 0, 1, 0, 0, 0, P3,   D3);
    vecs[13] = mk(1, 1, 1, 1, 1, 1, 1, P1,   H256);
    vecs[14] = mk(0, 0, 0, 1, 0, 1, 0, C1,   P1);
    vecs[15] = mk(1, 0, 1, 1, 1, 1, 1, P1,   Y0_256);
    vecs[16] = mk(0, 0, 0, 1, 0, 1, 0, C1,   P1);

    lat_ref[0] = 0;
    lat_ref[1] = 0;
    iRstn = 1'b0; iInit = 1'b0; iIV = '0; iIV_valid = 1'b0; iKey = '0; iKey_valid = 1'b0;
    iKeylen = 1'b0; iHashKey = 1'b0; iY0 = 1'b0; iBlock = '0; iBlock_valid = 1'b0;
    repeat (3) @(negedge iClk);
    check128("por_result", oResult, ZERO);
    check_int("por_valid", oResult_valid == 1'b0, int'(oResult_valid), 0);
    iRstn = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].rst) do_reset();
      run_op(vecs[i].hk, vecs[i].y0, vecs[i].bv, vecs[i].kv, vecs[i].kl, vecs[i].ivv,
             vecs[i].blk, vecs[i].exp, $sformatf("vec%0d", i), 1'b0);
    end

    // Requests raised while busy are ignored; the result then holds.
    run_op(0, 0, 1, 0, 1, 0, C2, P2, "busy_ignore", 1'b1);
    watch_quiet("hold_after_done", 30, P2);

    // Reset in the middle of RUN aborts without a pulse; counter restarts.
    do_reset();
    @(negedge iClk);
    iInit = 1'b1; iBlock_valid = 1'b1; iBlock = P1; iKey_valid = 1'b1; iKey = K256;
    iKeylen = 1'b1; iIV_valid = 1'b1; iIV = IV;
    @(posedge iClk);
    #1;
    iInit = 1'b0; iBlock_valid = 1'b0;
    repeat (6) @(negedge iClk);
    iRstn = 1'b0;
    #1;
    check_int("midrun_reset_valid", oResult_valid == 1'b0, int'(oResult_valid), 0);
    check128("midrun_reset_result", oResult, ZERO);
    @(negedge iClk);
    iRstn = 1'b1;
    watch_quiet("midrun_no_pulse", 30, ZERO);
    run_op(0, 0, 1, 1, 1, 1, C1, P1, "after_abort_ctr2", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute guard so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "global timeout");
  end

endmodule : tb_gctr_block
`default_nettype wire
